array_rw_init_ext: RTL and testbench
====================================

# array_rw_init_ext

Parametrised single-port (1RW) SRAM model, the next-generation form of the fixed-geometry `*_ext` array macros. Depth, width and write-mask granularity are parameters, and read latency is 1 or 2 cycles. It adds a built-in clear engine that sweeps the whole array to a fixed value after reset or on request, and a read-valid strobe. It sits behind cache/TLB/predictor arrays wherever a generated memory macro is instantiated.

## Interface
- DEPTH, 4096, number of words (≥2; need not be a power of two)
- WIDTH, 32, bits per word
- MASK_GRAN, 8, bits per write-mask segment; WIDTH must be a multiple of MASK_GRAN; MW = WIDTH/MASK_GRAN
- READ_LAT, 1, read latency in cycles, 1 or 2
- INIT_ON_RESET, 1, 1 = run clear sweep after reset
- INIT_VALUE, 0, WIDTH-bit word written by the clear sweep
- Derived: AW = clog2(DEPTH)
- RW0_clk  in  1  clock; all logic on rising edge
- RW0_rst_n  in  1  reset, synchronous, active-low
- RW0_addr  in  AW  word address
- RW0_en  in  1  access request
- RW0_wmode  in  1  1 = write, 0 = read
- RW0_wdata  in  WIDTH  write data
- RW0_wmask  in  MW  per-segment write enable; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN]
- RW0_rdata  out  WIDTH  read data
- RW0_rvalid  out  1  one-cycle strobe, rdata carries a new read result
- init_start  in  1  request a clear sweep
- init_busy  out  1  clear sweep in progress; accesses ignored while high

## Operation
- Access accepted when RW0_en=1 and init_busy=0. Accesses while init_busy=1 are dropped: no write, no rvalid.
- Write: for each i with wmask[i]=1, the segment is updated. Segments with wmask[i]=0 are unchanged. wmask=0 is a legal no-op write.
- Read: the word at addr is captured into the output pipeline. rdata holds the last read result until the next accepted read completes. Later writes to the same address do not alter a held rdata.
- Out-of-range address (addr ≥ DEPTH): write dropped; read completes normally with rdata = 0 and rvalid = 1.
- Clear FSM, states IDLE and CLEAR:
  - Reset → CLEAR with counter = 0 if INIT_ON_RESET=1, else → IDLE.
  - IDLE with init_start=1 → CLEAR next cycle, counter = 0.
  - CLEAR writes INIT_VALUE to the word at counter, one word per cycle, then increments the counter.
  - After the write at counter = DEPTH-1, the FSM returns to IDLE. The sweep takes exactly DEPTH cycles.
  - init_start is ignored while in CLEAR.
- init_busy = 1 exactly when the state is CLEAR.
- Reset values: RW0_rdata = 0, RW0_rvalid = 0, all read-pipeline stages invalid, counter = 0, init_busy = INIT_ON_RESET.
- Array contents are not reset. Without a sweep, the simulation initial value is X, or random under RANDOMIZE_MEM_INIT.
- Reset mid-sweep restarts the sweep from address 0. Reset also flushes in-flight reads: no rvalid is issued for reads accepted before reset.

## Timing
- Read accepted in cycle N → rdata/rvalid at N+1 (READ_LAT=1) or N+2 (READ_LAT=2). rvalid is high for exactly one cycle per accepted read.
- Fully pipelined: one accepted access per cycle, reads and writes interleaved freely. rvalid pulses preserve request order.
- Write in cycle N is visible to a read accepted in cycle N+1 or later.
- Sweep started by reset release in cycle 0 writes addr k in cycle k. init_busy falls in cycle DEPTH, and an access in cycle DEPTH is accepted.
- With READ_LAT=2, a read accepted in the last cycle before reset asserts produces no rvalid.
- init_start pulsed in cycle N while IDLE → init_busy = 1 from N+1 to N+DEPTH.

## Test plan
- Reset clear: DEPTH=16, INIT_VALUE=0xA5A5A5A5. Release reset, wait for init_busy to fall → falls after exactly 16 cycles. Reading all 16 addresses returns 0xA5A5A5A5 with one rvalid each.
- Masked write: WIDTH=32, MASK_GRAN=8. Write 0x11223344 to addr 3 with mask 0xF, then 0xAABBCCDD with mask 0x5 → read of addr 3 returns 0x11BB33DD.
- Latency/pipelining: READ_LAT=2, back-to-back reads of addrs 0,1,2 in cycles N..N+2 → rvalid high in N+2..N+4 with data in order. Write then immediate read of the same address returns the new data.
- Blocked access: init_start pulse, then writes issued during busy → those addresses still hold INIT_VALUE. No rvalid for reads issued during busy.
- Reset mid-sweep: assert RW0_rst_n=0 at counter=7, release → init_busy stays high for a full DEPTH cycles. Second init_start pulse during busy is ignored.
- Non-power-of-two: DEPTH=12. Write to addr 13 → no array change. Read of addr 13 → rdata = 0, rvalid = 1. rdata then holds its value through 5 idle cycles and an intervening write.

Source files
------------

// File: rtl/array_rw_init_ext.sv
// ---------------------------------------------------------------------------
// array_rw_init_ext
//
// Single-port (1RW) SRAM model with parametrised geometry, per-segment write
// mask, 1- or 2-cycle read latency, a read-valid strobe and a built-in clear
// engine that sweeps INIT_VALUE through every word after reset and/or on an
// init_start request.
//
// Handshake: an access is taken in any cycle where RW0_en=1 and init_busy=0;
// there is no back-pressure, so one access per cycle may be issued. A read
// taken in cycle N raises RW0_rvalid for exactly one cycle at N+READ_LAT with
// its word on RW0_rdata; RW0_rdata holds that word until the next read result
// arrives. Accesses presented while init_busy=1 are dropped entirely.
//
// Ports
//   RW0_clk      in   clock, rising edge
//   RW0_rst_n    in   synchronous active-low reset
//   RW0_addr     in   word address (AW bits)
//   RW0_en       in   access request
//   RW0_wmode    in   1 = write, 0 = read
//   RW0_wdata    in   write data
//   RW0_wmask    in   per-segment write enable (MW bits)
//   RW0_rdata    out  read data, held between read results
//   RW0_rvalid   out  one-cycle strobe per read result
//   init_start   in   request a clear sweep (ignored while sweeping)
//   init_busy    out  clear sweep in progress
//   dbg_state_o  out  clear FSM state (0 = IDLE, 1 = CLEAR)
// ---------------------------------------------------------------------------
module array_rw_init_ext #(
    parameter int unsigned      DEPTH         = 4096,
    parameter int unsigned      WIDTH         = 32,
    parameter int unsigned      MASK_GRAN     = 8,
    parameter int unsigned      READ_LAT      = 1,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int unsigned     MW            = WIDTH / MASK_GRAN,
    localparam int unsigned     AW            = $clog2(DEPTH)
) (
    input  logic             RW0_clk,
    input  logic             RW0_rst_n,
    input  logic [AW-1:0]    RW0_addr,
    input  logic             RW0_en,
    input  logic             RW0_wmode,
    input  logic [WIDTH-1:0] RW0_wdata,
    input  logic [MW-1:0]    RW0_wmask,
    output logic [WIDTH-1:0] RW0_rdata,
    output logic             RW0_rvalid,
    input  logic             init_start,
    output logic             init_busy,
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Storage is deliberately not reset; only the clear sweep initialises it.
    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic             acc;
    logic             rd_acc;
    logic             wr_acc;
    logic             in_range;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign init_busy   = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;

    assign acc    = RW0_en && !init_busy;
    assign rd_acc = acc && !RW0_wmode;
    assign wr_acc = acc && RW0_wmode;

    // DEPTH need not be a power of two, so the top of the address space can
    // be unbacked. Those addresses read as zero and swallow writes.
    assign in_range = ({1'b0, RW0_addr} < (AW + 1)'(DEPTH));

    assign rd_word = in_range ? mem_q[RW0_addr] : '0;

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state_q <= INIT_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // The last word is written in the same cycle the FSM decides
                // to leave, so the sweep occupies exactly DEPTH cycles.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array write port: clear sweep has priority, user writes are already
    // blocked whenever the sweep runs. Nothing is written during reset so a
    // reset mid-sweep leaves the array untouched until the sweep restarts.
    // ------------------------------------------------------------------
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= INIT_VALUE;
            end else if (wr_acc && in_range) begin
                for (int i = 0; i < int'(MW); i++) begin
                    if (RW0_wmask[i]) begin
                        mem_q[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <=
                            RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. The word is captured at acceptance, so later writes to
    // the same address never disturb an in-flight or held result.
    // ------------------------------------------------------------------
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             s1_vld_q;
            logic [WIDTH-1:0] s1_data_q;

            always_ff @(posedge RW0_clk) begin
                if (!RW0_rst_n) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                    rvalid_q  <= 1'b0;
                    rdata_q   <= '0;
                end else begin
                    s1_vld_q <= rd_acc;
                    if (rd_acc) begin
                        s1_data_q <= rd_word;
                    end
                    rvalid_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        rdata_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge RW0_clk) begin
                if (!RW0_rst_n) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= rd_word;
                    end
                end
            end
        end
    endgenerate

    assign RW0_rdata  = rdata_q;
    assign RW0_rvalid = rvalid_q;

endmodule

// File: tb/tb_array_rw_init_ext.sv
// ---------------------------------------------------------------------------
// Bench for array_rw_init_ext. Two instances share every input: one with
// READ_LAT=1 and one with READ_LAT=2, both DEPTH=12 (non-power-of-two) and a
// reset-time sweep of 0xA5A5A5A5. A reference model of the array, the clear
// sweep and the read-result queues is updated on every rising edge; each
// falling edge compares both instances against it. Scenario tasks add their
// own direct checks against hand-derived values.
// ---------------------------------------------------------------------------
module tb_array_rw_init_ext;

    localparam int          DEPTH  = 12;
    localparam int          WIDTH  = 32;
    localparam int          MG     = 8;
    localparam int          MW     = WIDTH / MG;
    localparam int          AW     = 4;
    localparam logic [31:0] INIT_V = 32'hA5A5A5A5;

    // ---------------- clock / reset / stimulus signals ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          wmode = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [31:0]   wdata = '0;
    logic [MW-1:0] wmask = '0;

    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, busy1, busy2, dbg1, dbg2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    array_rw_init_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MG), .READ_LAT(1),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_V)
    ) dut_l1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
        .RW0_rdata(rdata1), .RW0_rvalid(rvalid1), .init_start(start),
        .init_busy(busy1), .dbg_state_o(dbg1)
    );

    array_rw_init_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MG), .READ_LAT(2),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_V)
    ) dut_l2 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
        .RW0_rdata(rdata2), .RW0_rvalid(rvalid2), .init_start(start),
        .init_busy(busy2), .dbg_state_o(dbg2)
    );

    // ---------------- reference model ----------------
    logic [31:0] mem_m [DEPTH];
    logic        busy_m  = 1'b0;
    int          clr_idx = 0;
    int          edge_n  = 0;
    bit          sb_on   = 1'b0;

    // Expected read results per instance, with the edge after which each
    // result must be visible on the outputs.
    logic [31:0] exp1_q[$];
    logic [31:0] exp2_q[$];
    int          due1_q[$];
    int          due2_q[$];

    logic        ev1 = 1'b0, ev2 = 1'b0;
    logic [31:0] ed1 = '0, ed2 = '0;

    always @(posedge clk) begin : model
        logic [31:0] rd;
        logic [31:0] m;
        edge_n++;
        if (!rst_n) begin
            busy_m  = 1'b1;
            clr_idx = 0;
            exp1_q.delete(); exp2_q.delete();
            due1_q.delete(); due2_q.delete();
            ev1 = 1'b0; ed1 = '0;
            ev2 = 1'b0; ed2 = '0;
            sb_on = 1'b1;
        end else begin
            if (en && !busy_m) begin
                if (wmode) begin
                    if (int'(addr) < DEPTH) begin
                        m = '0;
                        for (int i = 0; i < MW; i++)
                            if (wmask[i]) m[i*MG +: MG] = 8'hFF;
                        mem_m[addr] = (mem_m[addr] & ~m) | (wdata & m);
                    end
                end else begin
                    rd = (int'(addr) < DEPTH) ? mem_m[addr] : 32'h0;
                    exp1_q.push_back(rd); due1_q.push_back(edge_n);
                    exp2_q.push_back(rd); due2_q.push_back(edge_n + 1);
                end
            end
            if (busy_m) begin
                mem_m[clr_idx] = INIT_V;
                clr_idx++;
                if (clr_idx == DEPTH) busy_m = 1'b0;
            end else if (start) begin
                busy_m  = 1'b1;
                clr_idx = 0;
            end
            ev1 = 1'b0;
            if (due1_q.size() > 0 && due1_q[0] == edge_n) begin
                ev1 = 1'b1; ed1 = exp1_q.pop_front(); void'(due1_q.pop_front());
            end
            ev2 = 1'b0;
            if (due2_q.size() > 0 && due2_q[0] == edge_n) begin
                ev2 = 1'b1; ed2 = exp2_q.pop_front(); void'(due2_q.pop_front());
            end
        end
    end

    // ---------------- scoreboard: every falling edge ----------------
    always @(negedge clk) begin
        if (sb_on) begin
            checks++;
            if (busy1 !== busy_m || busy2 !== busy_m || dbg1 !== busy_m || dbg2 !== busy_m) begin
                errors++;
                $display("FAIL sb_busy edge %0d: busy %b/%b state %b/%b, expected %b",
                         edge_n, busy1, busy2, dbg1, dbg2, busy_m);
            end
            checks++;
            if (rvalid1 !== ev1 || rdata1 !== ed1) begin
                errors++;
                $display("FAIL sb_lat1 edge %0d: rvalid %b rdata %h, expected %b %h",
                         edge_n, rvalid1, rdata1, ev1, ed1);
            end
            checks++;
            if (rvalid2 !== ev2 || rdata2 !== ed2) begin
                errors++;
                $display("FAIL sb_lat2 edge %0d: rvalid %b rdata %h, expected %b %h",
                         edge_n, rvalid2, rdata2, ev2, ed2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic op(input logic e, input logic w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [MW-1:0] mk);
        @(negedge clk);
        en = e; wmode = w; addr = a; wdata = d; wmask = mk; start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        en = 1'b0; wmode = 1'b0; start = 1'b1;
    endtask

    // Counts falling edges until init_busy drops, bounded.
    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n, c1, c2;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0
            || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: rdata %h/%h rvalid %b/%b busy %b/%b, expected 0/0 0/0 1/1",
                     rdata1, rdata2, rvalid1, rvalid2, busy1, busy2);
        end
        rst_n = 1'b1;
        wait_busy_low(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_sweep_len: busy for %0d cycles, expected %0d", n, DEPTH);
        end
        c1 = 0; c2 = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) op(1'b1, 1'b0, AW'(i), '0, '0);
            else           idle(1);
            if (rvalid1 === 1'b1) begin
                c1++;
                checks++;
                if (rdata1 !== INIT_V) begin
                    errors++;
                    $display("FAIL reset_clear_l1: rdata %h, expected %h", rdata1, INIT_V);
                end
            end
            if (rvalid2 === 1'b1) begin
                c2++;
                checks++;
                if (rdata2 !== INIT_V) begin
                    errors++;
                    $display("FAIL reset_clear_l2: rdata %h, expected %h", rdata2, INIT_V);
                end
            end
        end
        checks++;
        if (c1 != DEPTH || c2 != DEPTH) begin
            errors++;
            $display("FAIL reset_clear_count: rvalids %0d/%0d, expected %0d", c1, c2, DEPTH);
        end
    endtask

    task automatic test_masked_write();
        op(1'b1, 1'b1, 4'd3, 32'h11223344, 4'hF);
        op(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'h5);
        op(1'b1, 1'b1, 4'd3, 32'h99999999, 4'h0);   // empty mask: no change
        op(1'b1, 1'b0, 4'd3, '0, '0);
        idle(1);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL masked_l1: rvalid %b rdata %h, expected 1 11bb33dd", rvalid1, rdata1);
        end
        idle(1);
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 32'h11BB33DD || rvalid1 !== 1'b0 || rdata1 !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL masked_l2: rvalid %b/%b rdata %h/%h, expected 0/1 11bb33dd",
                     rvalid1, rvalid2, rdata1, rdata2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [3];
        logic [31:0] x;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            op(1'b1, 1'b1, AW'(i), d[i], 4'hF);
        end
        for (int j = 0; j < 6; j++) begin
            if (j < 3) op(1'b1, 1'b0, AW'(j), '0, '0);
            else       idle(1);
            checks++;
            if (rvalid2 !== (j >= 2 && j <= 4) || (j >= 2 && j <= 4 && rdata2 !== d[j-2])) begin
                errors++;
                $display("FAIL b2b_l2 step %0d: rvalid %b rdata %h", j, rvalid2, rdata2);
            end
            checks++;
            if (rvalid1 !== (j >= 1 && j <= 3) || (j >= 1 && j <= 3 && rdata1 !== d[j-1])) begin
                errors++;
                $display("FAIL b2b_l1 step %0d: rvalid %b rdata %h", j, rvalid1, rdata1);
            end
        end
        x = $urandom;
        op(1'b1, 1'b1, 4'd7, x, 4'hF);
        op(1'b1, 1'b0, 4'd7, '0, '0);
        idle(2);
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== x || rdata1 !== x) begin
            errors++;
            $display("FAIL wr_then_rd: rvalid %b rdata %h/%h, expected 1 %h", rvalid2, rdata1, rdata2, x);
        end
    endtask

    task automatic test_blocked();
        int n;
        idle(3);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i < 2) op(1'b1, 1'b1, AW'(5 + i), $urandom, 4'hF);
            else       op(1'b1, 1'b0, 4'd5, '0, '0);
            checks++;
            if (busy2 !== 1'b1 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
                errors++;
                $display("FAIL blocked_busy step %0d: busy %b rvalid %b/%b, expected 1 0/0",
                         i, busy2, rvalid1, rvalid2);
            end
        end
        en = 1'b0;
        wait_busy_low(n);
        checks++;
        if (n != DEPTH - 3) begin
            errors++;
            $display("FAIL blocked_sweep_len: %0d further cycles, expected %0d", n, DEPTH - 3);
        end
        op(1'b1, 1'b0, 4'd5, '0, '0);
        op(1'b1, 1'b0, 4'd6, '0, '0);
        idle(1);
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== INIT_V) begin
            errors++;
            $display("FAIL blocked_wr5: rvalid %b rdata %h, expected 1 %h", rvalid2, rdata2, INIT_V);
        end
        idle(1);
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== INIT_V) begin
            errors++;
            $display("FAIL blocked_wr6: rvalid %b rdata %h, expected 1 %h", rvalid2, rdata2, INIT_V);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        idle(2);
        pulse_start();
        idle(8);             // sweep is now writing word 7
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            @(negedge clk);
            start = (n == 2); // pulse while busy: must be ignored
            n++;
        end
        start = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_sweep_len: busy for %0d cycles, expected %0d", n, DEPTH);
        end
        idle(2);
        checks++;
        if (busy2 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL second_start_ignored: busy %b/%b, expected 0/0", busy1, busy2);
        end
    endtask

    task automatic test_reset_flush();
        int n;
        op(1'b1, 1'b0, 4'd2, '0, '0);
        idle(1);
        rst_n = 1'b0;
        checks++;
        if (rvalid1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_l1_before_reset: rvalid %b, expected 1", rvalid1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvalid2 !== 1'b0 || rvalid1 !== 1'b0 || rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL flush_l2 step %0d: rvalid %b/%b rdata %h, expected 0/0 0",
                         i, rvalid1, rvalid2, rdata2);
            end
            @(negedge clk);
        end
        wait_busy_low(n);
    endtask

    task automatic test_out_of_range();
        logic [31:0] v;
        v = $urandom | 32'h1;
        op(1'b1, 1'b1, 4'd4, v, 4'hF);
        op(1'b1, 1'b1, 4'd13, $urandom, 4'hF);
        op(1'b1, 1'b0, 4'd13, '0, '0);
        idle(2);
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: rvalid %b rdata %h/%h, expected 1 0", rvalid2, rdata1, rdata2);
        end
        op(1'b1, 1'b0, 4'd4, '0, '0);
        idle(5);
        op(1'b1, 1'b1, 4'd4, ~v, 4'hF);
        idle(2);
        checks++;
        if (rdata1 !== v || rdata2 !== v || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold: rdata %h/%h rvalid %b/%b, expected %h 0/0",
                     rdata1, rdata2, rvalid1, rvalid2, v);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 400; i++) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, 15)), $urandom, MW'($urandom_range(0, 15)));
            start = ($urandom_range(0, 63) == 0);
        end
        idle(1);
        wait_busy_low(n);
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, AW'(a), '0, '0);
        idle(3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_blocked();
        test_reset_mid_sweep();
        test_reset_flush();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
